// File: rtl/axi4_rd_fifo_pkg.sv
// ---------------------------------------------------------------------------
// axi4_rd_fifo_pkg
//   Shared constants and types for the AXI4 read-side FIFO bridge.
//   - RESP_OKAY / RESP_DECERR : RRESP encodings used by the read FSM
//   - rd_state_e              : read channel FSM state type
// ---------------------------------------------------------------------------
package axi4_rd_fifo_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR  = 2'd2
    } rd_state_e;

endpackage

// File: rtl/axi4_rd_fifo_packer.sv
// ---------------------------------------------------------------------------
// dbi_rx_packer
//   Packs DBI RX PHY bytes into DATA_W words, first byte in the LSB lane.
//   A completed word is held until the word FIFO takes it; a partial word is
//   never released.
//   Ports:
//     clk, rst          : clock, synchronous active-high reset
//     drp_d_data_i/vld_i: incoming byte and its valid
//     drp_d_rdy_o       : byte accept (low only while a full word waits on a
//                         full FIFO)
//     fifo_full_i       : word FIFO is full
//     word_take_i       : FIFO consumes the held word this cycle
//     word_o/word_vld_o : assembled word and "complete" flag
// ---------------------------------------------------------------------------
module dbi_rx_packer #(
    parameter int DATA_W     = 256,
    parameter int DBI_IF_D_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DBI_IF_D_W-1:0] drp_d_data_i,
    input  logic                  drp_d_vld_i,
    output logic                  drp_d_rdy_o,
    input  logic                  fifo_full_i,
    input  logic                  word_take_i,
    output logic [DATA_W-1:0]     word_o,
    output logic                  word_vld_o
);

    localparam int LANES = DATA_W / DBI_IF_D_W;
    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANES-1:0][DBI_IF_D_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic                             cmpl_q, cmpl_d;
    logic                             byte_acc;

    // Bytes keep flowing across a word boundary as long as the held word can
    // drain this cycle; when the FIFO is not full the take happens in the
    // same cycle, so lane 0 of the next word never clobbers an unsent word.
    assign drp_d_rdy_o = ~cmpl_q | ~fifo_full_i;
    assign byte_acc    = drp_d_vld_i & drp_d_rdy_o;
    assign word_o      = word_q;
    assign word_vld_o  = cmpl_q;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        cmpl_d = cmpl_q & ~word_take_i;
        if (byte_acc) begin
            word_d[cnt_q] = drp_d_data_i;
            if (cnt_q == CNT_W'(LANES - 1)) begin
                cnt_d  = '0;
                cmpl_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            cnt_q  <= '0;
            cmpl_q <= 1'b0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
            cmpl_q <= cmpl_d;
        end
    end

endmodule

// File: rtl/axi4_rd_fifo.sv
// ---------------------------------------------------------------------------
// axi4_rd_fifo
//   AXI4 read slave with a single mapped address. Bytes from the DBI RX PHY
//   are packed into DATA_W words and buffered in an R_FIFO_CAPAC-deep word
//   FIFO. A read burst to BASE_ADDR returns ARLEN+1 FIFO words (waiting for
//   them as needed); any other address returns ARLEN+1 DECERR beats with
//   zero data and leaves the FIFO alone.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     m_ar*        : AXI4 read address channel (slave side)
//     m_r*         : AXI4 read data channel (slave side)
//     drp_d_*      : byte stream from the DBI RX PHY
// ---------------------------------------------------------------------------
module axi4_rd_fifo
    import axi4_rd_fifo_pkg::*;
#(
    parameter int                DATA_W           = 256,
    parameter int                ADDR_W           = 32,
    parameter int                MST_ID_W         = 5,
    parameter int                TRANS_DATA_LEN_W = 8,
    parameter int                TRANS_RESP_W     = 2,
    parameter logic [ADDR_W-1:0] BASE_ADDR        = 32'h2000_0000,
    parameter int                DBI_IF_D_W       = 8,
    parameter int                R_FIFO_CAPAC     = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [MST_ID_W-1:0]         m_arid_i,
    input  logic [ADDR_W-1:0]           m_araddr_i,
    input  logic [TRANS_DATA_LEN_W-1:0] m_arlen_i,
    input  logic                        m_arvalid_i,
    output logic                        m_arready_o,
    output logic [MST_ID_W-1:0]         m_rid_o,
    output logic [DATA_W-1:0]           m_rdata_o,
    output logic [TRANS_RESP_W-1:0]     m_rresp_o,
    output logic                        m_rlast_o,
    output logic                        m_rvalid_o,
    input  logic                        m_rready_i,
    input  logic [DBI_IF_D_W-1:0]       drp_d_data_i,
    input  logic                        drp_d_vld_i,
    output logic                        drp_d_rdy_o
);

    localparam int PTR_W = $clog2(R_FIFO_CAPAC);

    // ---------------- packer ----------------
    logic [DATA_W-1:0] pk_word;
    logic              pk_vld;
    logic              fifo_full, fifo_empty;
    logic              push, pop;

    dbi_rx_packer #(
        .DATA_W     (DATA_W),
        .DBI_IF_D_W (DBI_IF_D_W)
    ) u_packer (
        .clk          (clk),
        .rst          (rst),
        .drp_d_data_i (drp_d_data_i),
        .drp_d_vld_i  (drp_d_vld_i),
        .drp_d_rdy_o  (drp_d_rdy_o),
        .fifo_full_i  (fifo_full),
        .word_take_i  (push),
        .word_o       (pk_word),
        .word_vld_o   (pk_vld)
    );

    // ---------------- word FIFO ----------------
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [DATA_W-1:0] mem_q [R_FIFO_CAPAC];
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign push = pk_vld & (~fifo_full | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= pk_word;
        end
    end

    // ---------------- read FSM ----------------
    rd_state_e                   state_q, state_d;
    logic [MST_ID_W-1:0]         arid_q, arid_d;
    logic [TRANS_DATA_LEN_W-1:0] len_q, len_d;
    logic [TRANS_DATA_LEN_W-1:0] beat_q, beat_d;
    logic                        ar_hs, r_hs, last;

    assign ar_hs = m_arvalid_i & m_arready_o;
    assign r_hs  = m_rvalid_o & m_rready_i;
    assign last  = (beat_q == len_q);
    assign pop   = (state_q == ST_DATA) & ~fifo_empty & m_rready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            arid_q   <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            arid_q   <= arid_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        arid_d  = arid_q;
        len_d   = len_q;
        beat_d  = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (ar_hs) begin
                    arid_d  = m_arid_i;
                    len_d   = m_arlen_i;
                    beat_d  = '0;
                    state_d = (m_araddr_i == BASE_ADDR) ? ST_DATA : ST_ERR;
                end
            end
            ST_DATA, ST_ERR: begin
                if (r_hs) begin
                    beat_d = beat_q + 1'b1;
                    if (last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs depend only on registered state/FIFO head, so they hold
    // steady while the master stalls.
    always_comb begin
        m_arready_o = 1'b0;
        m_rvalid_o  = 1'b0;
        m_rdata_o   = '0;
        m_rresp_o   = '0;
        m_rlast_o   = 1'b0;
        m_rid_o     = '0;
        case (state_q)
            ST_IDLE: m_arready_o = 1'b1;
            ST_DATA: begin
                m_rvalid_o = ~fifo_empty;
                m_rdata_o  = mem_q[rd_ptr_q[PTR_W-1:0]];
                m_rresp_o  = TRANS_RESP_W'(RESP_OKAY);
                m_rlast_o  = last;
                m_rid_o    = arid_q;
            end
            ST_ERR: begin
                m_rvalid_o = 1'b1;
                m_rresp_o  = TRANS_RESP_W'(RESP_DECERR);
                m_rlast_o  = last;
                m_rid_o    = arid_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi4_rd_fifo.sv
`timescale 1ns/1ps
module tb_axi4_rd_fifo;
    localparam int DATA_W = 256;
    localparam int ADDR_W = 32;
    localparam int ID_W   = 5;
    localparam int LEN_W  = 8;
    localparam int RESP_W = 2;
    localparam int D_W    = 8;
    localparam int CAP    = 8;
    localparam int LANES  = DATA_W / D_W;
    localparam logic [ADDR_W-1:0] BASE = 32'h2000_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ID_W-1:0]   m_arid_i = '0;
    logic [ADDR_W-1:0] m_araddr_i = '0;
    logic [LEN_W-1:0]  m_arlen_i = '0;
    logic              m_arvalid_i = 1'b0;
    logic              m_arready_o;
    logic [ID_W-1:0]   m_rid_o;
    logic [DATA_W-1:0] m_rdata_o;
    logic [RESP_W-1:0] m_rresp_o;
    logic              m_rlast_o;
    logic              m_rvalid_o;
    logic              m_rready_i = 1'b0;
    logic [D_W-1:0]    drp_d_data_i = '0;
    logic              drp_d_vld_i = 1'b0;
    logic              drp_d_rdy_o;

    always #5 clk = ~clk;

    axi4_rd_fifo dut (
        .clk(clk), .rst(rst),
        .m_arid_i(m_arid_i), .m_araddr_i(m_araddr_i), .m_arlen_i(m_arlen_i),
        .m_arvalid_i(m_arvalid_i), .m_arready_o(m_arready_o),
        .m_rid_o(m_rid_o), .m_rdata_o(m_rdata_o), .m_rresp_o(m_rresp_o),
        .m_rlast_o(m_rlast_o), .m_rvalid_o(m_rvalid_o), .m_rready_i(m_rready_i),
        .drp_d_data_i(drp_d_data_i), .drp_d_vld_i(drp_d_vld_i), .drp_d_rdy_o(drp_d_rdy_o)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [ID_W-1:0]   id;
        logic [RESP_W-1:0] resp;
        logic              last;
        logic              mapped;
    } exp_t;

    exp_t              exp_q[$];   // expected R beats, pushed at AR acceptance
    logic [DATA_W-1:0] word_q[$];  // completed words not yet read
    logic [D_W-1:0]    byte_q[$];  // bytes of the word being assembled
    exp_t              e;
    logic [DATA_W-1:0] build_w;

    int n_chk  = 0;
    int n_fail = 0;
    int rr_mode = 0;               // 0: ready=1, 1: random, 2: ready=0
    bit started = 0;
    bit just_rst = 0;
    bit stall = 0;
    logic [DATA_W-1:0] s_data;
    logic [ID_W-1:0]   s_id;
    logic [RESP_W-1:0] s_resp;
    logic              s_last;

    task automatic chk1(string name, bit act, bit req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0b want %0b at %0t", name, act, req, $time);
        end
    endtask

    task automatic chkw(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: checks at the falling edge, then applies this cycle's handshakes.
    initial forever begin
        @(negedge clk);
        if (started) begin
            chk1("arready", m_arready_o, exp_q.size() == 0);
            chk1("drp_rdy", drp_d_rdy_o, word_q.size() <= CAP);
            if (exp_q.size() == 0)
                chk1("rvalid_idle", m_rvalid_o, 1'b0);
            else if (m_rvalid_o && exp_q[0].mapped)
                chk1("rvalid_has_word", word_q.size() != 0, 1'b1);
            if (just_rst) begin
                chk1("rst_rvalid", m_rvalid_o, 1'b0);
                chk1("rst_rlast", m_rlast_o, 1'b0);
                chkw("rst_rdata", m_rdata_o, '0);
                chkw("rst_rresp", DATA_W'(m_rresp_o), '0);
                chkw("rst_rid", DATA_W'(m_rid_o), '0);
            end
            if (stall) begin
                chk1("hold_rvalid", m_rvalid_o, 1'b1);
                chkw("hold_rdata", m_rdata_o, s_data);
                chkw("hold_rid", DATA_W'(m_rid_o), DATA_W'(s_id));
                chkw("hold_rresp", DATA_W'(m_rresp_o), DATA_W'(s_resp));
                chk1("hold_rlast", m_rlast_o, s_last);
            end
        end
        stall = 0;
        just_rst = 0;
        if (rst) begin
            exp_q.delete();
            word_q.delete();
            byte_q.delete();
            just_rst = 1;
        end else if (started) begin
            if (m_arvalid_i && m_arready_o) begin
                for (int b = 0; b <= int'(m_arlen_i); b++) begin
                    e.id     = m_arid_i;
                    e.mapped = (m_araddr_i == BASE);
                    e.resp   = e.mapped ? 2'b00 : 2'b11;
                    e.last   = (b == int'(m_arlen_i));
                    exp_q.push_back(e);
                end
            end
            if (m_rvalid_o && m_rready_i && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chkw("rid", DATA_W'(m_rid_o), DATA_W'(e.id));
                chkw("rresp", DATA_W'(m_rresp_o), DATA_W'(e.resp));
                chk1("rlast", m_rlast_o, e.last);
                if (!e.mapped)
                    chkw("rdata_err", m_rdata_o, '0);
                else if (word_q.size() == 0)
                    chk1("rdata_avail", 1'b0, 1'b1);
                else
                    chkw("rdata", m_rdata_o, word_q.pop_front());
            end
            if (m_rvalid_o && !m_rready_i) begin
                stall  = 1;
                s_data = m_rdata_o;
                s_id   = m_rid_o;
                s_resp = m_rresp_o;
                s_last = m_rlast_o;
            end
            if (drp_d_vld_i && drp_d_rdy_o) begin
                byte_q.push_back(drp_d_data_i);
                if (byte_q.size() == LANES) begin
                    build_w = '0;
                    for (int k = 0; k < LANES; k++) build_w[k*D_W +: D_W] = byte_q[k];
                    word_q.push_back(build_w);
                    byte_q.delete();
                end
            end
        end
    end

    // R ready driver
    initial forever begin
        @(posedge clk);
        #1;
        case (rr_mode)
            0:       m_rready_i = 1'b1;
            1:       m_rready_i = 1'($urandom_range(0, 1));
            default: m_rready_i = 1'b0;
        endcase
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bytes(int n, int base, bit rnd, int gap_pct);
        for (int i = 0; i < n; i++) begin
            bit done = 0;
            for (int g = 0; g < 8 && $urandom_range(0, 99) < gap_pct; g++) tick();
            drp_d_vld_i  = 1'b1;
            drp_d_data_i = rnd ? 8'($urandom) : 8'(base + i);
            for (int w = 0; w < 3000 && !done; w++) begin
                @(negedge clk);
                done = drp_d_rdy_o;
                tick();
            end
            drp_d_vld_i = 1'b0;
            if (!done) begin
                chk1("byte_timeout", done, 1'b1);
                break;
            end
        end
    endtask

    task automatic do_ar(logic [ID_W-1:0] id, logic [ADDR_W-1:0] a, logic [LEN_W-1:0] len);
        bit done = 0;
        m_arvalid_i = 1'b1;
        m_arid_i    = id;
        m_araddr_i  = a;
        m_arlen_i   = len;
        for (int w = 0; w < 3000 && !done; w++) begin
            @(negedge clk);
            done = m_arready_o;
            tick();
        end
        chk1("ar_timeout", done, 1'b1);
        m_arvalid_i = 1'b0;
        m_araddr_i  = $urandom;
    endtask

    task automatic wait_idle(int budget);
        bit done = 0;
        for (int w = 0; w < budget && !done; w++) begin
            @(negedge clk);
            done = (exp_q.size() == 0);
            tick();
        end
        chk1("idle_timeout", done, 1'b1);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        logic [ADDR_W-1:0] a;
        int len;
        bit done;
        @(posedge clk);
        started = 1;
        #1;
        tick();
        tick();
        // reset cycle with an AR pending: must be ignored
        m_arvalid_i = 1'b1;
        m_araddr_i  = BASE;
        tick();
        m_arvalid_i = 1'b0;
        rst = 1'b0;

        // two-beat mapped read over bytes 0x00..0x3F
        rr_mode = 1;
        send_bytes(64, 0, 0, 0);
        do_ar(5'd3, BASE, 8'd1);
        wait_idle(300);

        // unmapped read leaves the stored word for the next mapped read
        send_bytes(32, 8'h40, 0, 0);
        do_ar(5'd7, BASE + 32'h40, 8'd3);
        wait_idle(300);
        do_ar(5'd1, BASE, 8'd0);
        wait_idle(300);

        // fill 8 FIFO words plus one held word: byte ready drops
        rr_mode = 0;
        send_bytes(9 * LANES, 0, 1, 0);
        repeat (3) tick();
        @(negedge clk);
        chk1("full_rdy_low", drp_d_rdy_o, 1'b0);
        tick();
        fork
            send_bytes(1, 0, 1, 0);
            begin
                repeat (5) tick();
                do_ar(5'd2, BASE, 8'd0);
            end
        join
        wait_idle(300);
        do_ar(5'd4, BASE, 8'd7);
        wait_idle(500);

        // one stray byte must not be released as a word
        do_ar(5'd5, BASE, 8'd0);
        repeat (20) tick();
        @(negedge clk);
        chk1("partial_no_flush", m_rvalid_o, 1'b0);
        tick();
        send_bytes(LANES - 1, 0, 1, 0);
        wait_idle(300);

        // master stall for 5 cycles mid-burst
        send_bytes(2 * LANES, 0, 1, 0);
        rr_mode = 2;
        do_ar(5'd6, BASE, 8'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("stall_arready", m_arready_o, 1'b0);
            chk1("stall_rvalid", m_rvalid_o, 1'b1);
            tick();
        end
        rr_mode = 0;
        wait_idle(300);

        // burst issued on an empty FIFO, words trickle in
        rr_mode = 1;
        fork
            do_ar(5'd8, BASE, 8'd3);
            send_bytes(4 * LANES, 0, 1, 60);
        join
        wait_idle(3000);

        // reset after the first beat of a 4-beat burst
        rr_mode = 0;
        send_bytes(4 * LANES, 0, 1, 0);
        do_ar(5'd9, BASE, 8'd3);
        done = 0;
        for (int w = 0; w < 200 && !done; w++) begin
            @(negedge clk);
            done = (exp_q.size() <= 3);
            tick();
        end
        chk1("first_beat_timeout", done, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk1("post_rst_rvalid", m_rvalid_o, 1'b0);
        chk1("post_rst_arready", m_arready_o, 1'b1);
        tick();
        do_ar(5'd10, BASE, 8'd0);
        repeat (20) tick();
        @(negedge clk);
        chk1("post_rst_fifo_empty", m_rvalid_o, 1'b0);
        tick();
        send_bytes(LANES, 0, 1, 0);
        wait_idle(300);

        // randomized mix
        rr_mode = 1;
        for (int it = 0; it < 25; it++) begin
            len = $urandom_range(0, 7);
            if ($urandom_range(0, 3) != 0) begin
                fork
                    do_ar(5'($urandom), BASE, 8'(len));
                    send_bytes((len + 1) * LANES, 0, 1, $urandom_range(0, 30));
                join
            end else begin
                a = $urandom;
                if (a == BASE) a = a ^ 32'h4;
                do_ar(5'($urandom), a, 8'(len));
            end
            wait_idle(3000);
        end

        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
